pulser_u_blank: RTL and testbench
=================================

# pulser_u_blank

Generates the amplifier unblanking gate (`u_blank`) for the NMR pulse sequencer. It repeats a two-pulse (pulse, gap, pulse) pattern every `record_len` clock cycles while enabled. The output brackets the RF pulses so the power amplifier is only unblanked during transmit windows. The block sits beside the RF pulse generator and shares its clock.

## Interface
- No parameters; all widths are fixed at 8 bits.
- `clk`  in  1  system clock; all logic is on the rising edge (nominal 200 MHz, 5 ns).
- `rst_n`  in  1  asynchronous, active-low reset.
- `record_len`  in  8  period length R, in clock cycles.
- `pulse_gap`  in  8  gap G, in cycles, between the end of pulse 1 and the start of pulse 2.
- `high`  in  8  width H, in cycles, of each unblank pulse.
- `enable`  in  1  level-sensitive run enable.
- `u_blank`  out  1  unblank gate, registered, active-high.

## Operation
- **States.** Two states: IDLE and RUN.
  - IDLE → RUN on a clock edge that samples `enable`=1 and R≠0.
  - RUN → IDLE on a clock edge that samples `enable`=0.
- **Counter.** 8-bit period counter `cnt`.
  - It is 0 in the first RUN cycle.
  - It increments each cycle and wraps from R−1 to 0.
- **Shadow registers.** Rs, Gs and Hs are loaded from the inputs on IDLE→RUN and on every wrap to 0.
  - Input changes mid-period take effect only at the next period start.
  - If a new R of 0 is captured at a wrap, go to IDLE.
- **Window decode.** Computed with 10-bit unsigned arithmetic, so no overflow.
  - The output is high in any cycle where state=RUN, cnt<Rs, and cnt is in [0, Hs) or in [Hs+Gs, 2·Hs+Gs).
  - Pulse 2, or any part of it, that falls at or beyond Rs is clipped, i.e. not generated.
  - Hs=0: the output stays low all period.
  - Gs=0: the two pulses merge into one pulse of 2·Hs cycles.
- **Registered output.** `u_blank` is a flop loaded from the decode of the next-cycle state/cnt, so it is aligned with `cnt` and glitch-free.
- **Wrap.** If the period ends inside a window and the next period starts high, `u_blank` stays continuously high across the wrap.

## Timing
- **Reset.** While `rst_n`=0: state=IDLE, cnt=0, shadow registers=0, `u_blank`=0, all asynchronously. Reset asserted mid-pulse drops `u_blank` immediately, without waiting for a clock edge.
- **Start latency.** From the first edge sampling `enable`=1, `u_blank` rises at that same edge if H≠0; this is cnt=0 of the first period.
- **Stop latency.** From the edge sampling `enable`=0, `u_blank` falls at that edge, cnt returns to 0, and the period is aborted.
- **Re-enable.** Always restarts at cnt=0 with freshly captured inputs.
- **Period.** Exactly Rs cycles; pulse 1 rises at cnt=0 of every period.
- **Edge cases.**
  - R=1: the output is constant high if H≥1.
  - R=255, G=255, H=255: the decode must not wrap.
  - The inputs are treated as quasi-static and are sampled only at period boundaries.

## Test plan
1. **Basic pattern.** R=100, G=50, H=10, `enable` held high after reset release → `u_blank` high at cnt 0–9 and 60–69, low elsewhere; 100-cycle period (500 ns at 5 ns clock), repeated for ≥5 periods.
2. **Clipping and wrap.** R=30, G=10, H=15 → high at cnt 0–14 and 25–29 (pulse 2 clipped); continuous high across the wrap from cnt 25 through cnt 14 of the next period.
3. **Degenerate settings.** G=0, H=10, R=100 → a single 20-cycle pulse at cnt 0–19. H=0 → `u_blank` never high. R=0 with `enable`=1 → stays IDLE, output low.
4. **Enable abort and restart.** Deassert `enable` at cnt 5 of pulse 1 → `u_blank` low at that edge. Reassert 7 cycles later → the new period starts at cnt 0 with a full 10-cycle pulse 1.
5. **Mid-period parameter change.** Change H from 10 to 20 at cnt 40 → the current period is still high only at cnt 60–69; the next period is high at cnt 0–19 and 70–89.
6. **Asynchronous reset.** Pulse `rst_n` low between clock edges during pulse 2 → `u_blank` drops before the next edge. After release, with `enable`=1, the sequence restarts at cnt 0.

Source files
------------

// File: rtl/pulser_u_blank.sv
// pulser_u_blank: amplifier unblank gate bracketing a repeating two-pulse pattern
module pulser_u_blank (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] record_len,
  input  logic [7:0] pulse_gap,
  input  logic [7:0] high,
  input  logic       enable,
  output logic       u_blank
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     state, state_d;
  logic [7:0] cnt, cnt_d, rs, gs, hs, rs_d, gs_d, hs_d;
  logic       start, wrap, load;
  logic [9:0] c, r, g, h;
  logic       win;
  assign start = state == IDLE && enable && record_len != 8'd0;
  assign wrap  = state == RUN && enable && cnt == rs - 8'd1;
  assign load  = start || wrap;
  // next state, counter and shadow values; period parameters only change at a period start
  always_comb begin
    rs_d    = load ? record_len : rs;
    gs_d    = load ? pulse_gap : gs;
    hs_d    = load ? high : hs;
    state_d = state == IDLE ? (start ? RUN : IDLE)
            : (!enable || (wrap && record_len == 8'd0)) ? IDLE : RUN;
    cnt_d   = (state_d == RUN && !load) ? cnt + 8'd1 : 8'd0;
  end
  // window decode of the upcoming cycle in 10 bits so 2*H+G cannot overflow
  always_comb begin
    c   = {2'b00, cnt_d};
    r   = {2'b00, rs_d};
    g   = {2'b00, gs_d};
    h   = {2'b00, hs_d};
    win = state_d == RUN && c < r && (c < h || (c >= h + g && c < (h << 1) + g));
  end
  // state, counter, shadows and the registered gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      rs      <= 8'd0;
      gs      <= 8'd0;
      hs      <= 8'd0;
      u_blank <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rs      <= rs_d;
      gs      <= gs_d;
      hs      <= hs_d;
      u_blank <= win;
    end
  end
endmodule

// File: tb/tb_pulser_u_blank.sv
// tb_pulser_u_blank: directed stimulus with a period-level reference model and literal pins
module tb_pulser_u_blank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] record_len = 8'd0;
  logic [7:0] pulse_gap = 8'd0;
  logic [7:0] high = 8'd0;
  logic       enable = 1'b0;
  logic       u_blank;
  int checks = 0;
  int errors = 0;
  int m_run = 0, m_pos = 0, m_r = 0, m_g = 0, m_h = 0;
  logic hist [0:599];

  pulser_u_blank dut (
    .clk(clk), .rst_n(rst_n), .record_len(record_len), .pulse_gap(pulse_gap),
    .high(high), .enable(enable), .u_blank(u_blank)
  );

  always #5 clk = ~clk;

  function automatic logic in_window(int pos, int r, int g, int h);
    return pos < r && (pos < h || (pos >= h + g && pos < 2 * h + g));
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: u_blank=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic capture();
    m_r = record_len;
    m_g = pulse_gap;
    m_h = high;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (enable && record_len != 0) begin
        m_run = 1;
        m_pos = 0;
        capture();
      end
    end else if (!enable) begin
      m_run = 0;
      m_pos = 0;
    end else if (m_pos == m_r - 1) begin
      capture();
      m_pos = 0;
      if (m_r == 0) m_run = 0;
    end else m_pos++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", u_blank, m_run != 0 && in_window(m_pos, m_r, m_g, m_h));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hist[i] = u_blank;
    end
  endtask

  task automatic cfg(input int r, input int g, input int h);
    record_len = 8'(r);
    pulse_gap  = 8'(g);
    high       = 8'(h);
  endtask

  task automatic stop();
    enable = 1'b0;
    tick();
    chk("stop_low", u_blank, 1'b0);
    run(3);
  endtask

  initial begin
    #12;
    chk("reset_low", u_blank, 1'b0);
    rst_n = 1'b1;
    run(2);
    cfg(100, 50, 10);
    enable = 1'b1;
    run(520);
    chk("t1_c0", hist[0], 1'b1);
    chk("t1_c9", hist[9], 1'b1);
    chk("t1_c10", hist[10], 1'b0);
    chk("t1_c59", hist[59], 1'b0);
    chk("t1_c60", hist[60], 1'b1);
    chk("t1_c69", hist[69], 1'b1);
    chk("t1_c70", hist[70], 1'b0);
    chk("t1_c99", hist[99], 1'b0);
    chk("t1_p1c0", hist[100], 1'b1);
    chk("t1_p4c60", hist[460], 1'b1);
    chk("t1_p4c70", hist[470], 1'b0);
    stop();
    cfg(30, 10, 15);
    enable = 1'b1;
    run(90);
    chk("t2_c14", hist[14], 1'b1);
    chk("t2_c15", hist[15], 1'b0);
    chk("t2_c24", hist[24], 1'b0);
    chk("t2_c25", hist[25], 1'b1);
    chk("t2_c29", hist[29], 1'b1);
    chk("t2_wrap", hist[30], 1'b1);
    chk("t2_p1c14", hist[44], 1'b1);
    chk("t2_p1c15", hist[45], 1'b0);
    stop();
    cfg(100, 0, 10);
    enable = 1'b1;
    run(110);
    chk("t3_merge19", hist[19], 1'b1);
    chk("t3_merge20", hist[20], 1'b0);
    stop();
    cfg(50, 5, 0);
    enable = 1'b1;
    run(110);
    chk("t3_h0_c0", hist[0], 1'b0);
    chk("t3_h0_c5", hist[5], 1'b0);
    stop();
    cfg(0, 5, 10);
    enable = 1'b1;
    run(20);
    chk("t3_r0", hist[5], 1'b0);
    stop();
    cfg(1, 0, 1);
    enable = 1'b1;
    run(10);
    chk("r1_high", hist[7], 1'b1);
    stop();
    cfg(255, 255, 255);
    enable = 1'b1;
    run(300);
    chk("max_c254", hist[254], 1'b1);
    chk("max_wrap", hist[255], 1'b1);
    stop();
    cfg(100, 50, 10);
    enable = 1'b1;
    run(6);
    enable = 1'b0;
    tick();
    chk("t4_abort", u_blank, 1'b0);
    run(6);
    enable = 1'b1;
    run(12);
    chk("t4_restart0", hist[0], 1'b1);
    chk("t4_restart9", hist[9], 1'b1);
    chk("t4_restart10", hist[10], 1'b0);
    stop();
    enable = 1'b1;
    run(41);
    high = 8'd20;
    for (int i = 41; i < 200; i++) begin
      tick();
      hist[i] = u_blank;
    end
    chk("t5_c60", hist[60], 1'b1);
    chk("t5_c69", hist[69], 1'b1);
    chk("t5_c70", hist[70], 1'b0);
    chk("t5_p1c19", hist[119], 1'b1);
    chk("t5_p1c20", hist[120], 1'b0);
    chk("t5_p1c70", hist[170], 1'b1);
    chk("t5_p1c89", hist[189], 1'b1);
    chk("t5_p1c90", hist[190], 1'b0);
    stop();
    high = 8'd10;
    enable = 1'b1;
    run(65);
    chk("t6_pre", hist[64], 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("t6_async_drop", u_blank, 1'b0);
    m_run = 0;
    m_pos = 0;
    m_r = 0;
    m_g = 0;
    m_h = 0;
    #2 rst_n = 1'b1;
    run(20);
    chk("t6_restart0", hist[0], 1'b1);
    chk("t6_restart10", hist[10], 1'b0);
    stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
